// File: rtl/mem_stage.sv
// Memory-access stage between EXE and WB: latches the EXE payload, aligns and extends
// load data, holds SRAM read data across WB stalls. Optional misaligned-load check: MEM_ALE_CHECK_EN.
module mem_stage #(
    parameter int EXE_TO_MEM_W = 112,
    parameter int MEM_TO_WB_W  = 70,
    parameter int MEM_RF_W     = 37
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [EXE_TO_MEM_W-1:0] EXE_to_MEM_BUS,
    input  logic                    EXE_to_MEM_valid,
    output logic                    MEM_allowin,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_W-1:0]  MEM_to_WB_BUS,
    output logic                    MEM_to_WB_valid,
    input  logic                    WB_allowin,
    output logic [MEM_RF_W-1:0]     MEM_RF_BUS,
    output logic                    mem_ale
);

    logic                    mem_valid_q, mem_valid_d;
    logic [EXE_TO_MEM_W-1:0] bus_q, bus_d;
    logic                    first_q, first_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [31:0]             hold_data_q, hold_data_d;

    logic        mem_ready_go;
    logic        accept;
    logic        leave;

    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result;
    logic [31:0] mem_sum;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [3:0]  load_op;
    logic        rfrom_mem;

    logic [31:0] load_word;
    logic [31:0] final_result;
    logic        gr_we_out;
    logic        unused_fields;

    // load_op = {ld_b, ld_h, ld_bu, ld_hu}; none set means a full word
    function automatic logic [31:0] align_load(input logic [3:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[{off, 3'b000} +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        if (op[3])      return {{24{byte_v[7]}}, byte_v};
        else if (op[2]) return {{16{half_v[15]}}, half_v};
        else if (op[1]) return {24'd0, byte_v};
        else if (op[0]) return {16'd0, half_v};
        else            return word;
    endfunction

    assign mem_ready_go = 1'b1;

    always_comb begin
        MEM_allowin  = !mem_valid_q || (mem_ready_go && WB_allowin);
        accept       = EXE_to_MEM_valid && MEM_allowin;
        leave        = mem_valid_q && mem_ready_go && WB_allowin;
        mem_valid_d  = MEM_allowin ? EXE_to_MEM_valid : mem_valid_q;
        bus_d        = accept ? EXE_to_MEM_BUS : bus_q;
        first_d      = accept;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        // rdata is only valid in the first MEM cycle; capture it if WB is stalling then
        if (first_q && mem_valid_q && !WB_allowin) begin
            hold_data_d  = data_sram_rdata;
            hold_valid_d = 1'b1;
        end
        if (accept || leave) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            bus_q        <= '0;
            first_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            bus_q        <= bus_d;
            first_q      <= first_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign {pc, gr_we, dest, exe_result, mem_sum, mem_en, mem_we, load_op, rfrom_mem} = bus_q;

    // Stores were already issued by EXE; their address and strobes are not needed here
    assign unused_fields = ^{mem_sum, mem_en, mem_we};

    assign load_word    = hold_valid_q ? hold_data_q : data_sram_rdata;
    assign final_result = rfrom_mem ? align_load(load_op, exe_result[1:0], load_word) : exe_result;

`ifdef MEM_ALE_CHECK_EN
    logic ld_w;
    logic ale;
    assign ld_w      = (load_op == 4'b0000);
    assign ale       = mem_valid_q && rfrom_mem &&
                       (((load_op[2] || load_op[0]) && exe_result[0]) ||
                        (ld_w && (exe_result[1:0] != 2'b00)));
    assign mem_ale   = ale;
    assign gr_we_out = gr_we && !ale;
`else
    assign mem_ale   = 1'b0;
    assign gr_we_out = gr_we;
`endif

    assign MEM_to_WB_valid = mem_valid_q;
    assign MEM_to_WB_BUS   = {pc, gr_we_out, dest, final_result};
    assign MEM_RF_BUS      = {dest & {5{gr_we_out & mem_valid_q}}, final_result};

endmodule
